// File: rtl/player_sequence_checker.sv
// player_sequence_checker
// Watches a four-step directional key sequence. A start request latches the
// expected sequence. The player then has TIMEOUT cycles between accepted keys
// to press each direction in order. The round ends in PASS after four correct
// keys, or in FAIL after a wrong key, several simultaneous keys, or a timeout.
// The expected-direction input is named sequence_i because "sequence" is a
// reserved word in SystemVerilog.
module player_sequence_checker #(
    parameter int unsigned TIMEOUT = 60
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] sequence_i,
    input  logic [3:0] key_press,
    output logic       busy,
    output logic [2:0] step,
    output logic       key_ack,
    output logic [1:0] last_dir,
    output logic       win,
    output logic       lose
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_KEY,
        ST_PASS,
        ST_FAIL
    } state_t;

    // A 20-bit counter covers the whole legal TIMEOUT range.
    localparam int unsigned       CNT_W    = 20;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [2:0]       step_q;
    logic [1:0]       last_dir_q;
    logic             key_ack_q;
    logic             busy_q;
    logic             win_q;
    logic             lose_q;
    logic [CNT_W-1:0] tmo_q;
    logic [7:0]       seq_q;
    logic [3:0]       key_prev_q;

    logic [3:0] key_rise;
    logic       key_event;
    logic       key_single;
    logic [1:0] key_dir;
    logic [1:0] expected_dir;
    logic [2:0] step_inc;
    logic       timeout_hit;

    // Remember last cycle's key levels so only 0->1 transitions count as events.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, whatever the block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_prev_q <= 4'b0000;
        end else begin
            key_prev_q <= key_press;
        end
    end

    // Decode the key event of this cycle and the direction expected at the current step.
    always_comb begin
        // NOTE: every signal gets a default before the case statements.
        // Otherwise a path that skips an assignment infers a latch.
        key_dir      = 2'b00;
        expected_dir = 2'b00;

        key_rise    = key_press & ~key_prev_q;
        key_event   = |key_rise;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        key_single  = key_event && ((key_rise & (key_rise - 4'd1)) == 4'b0000);
        step_inc    = step_q + 3'd1;
        timeout_hit = (tmo_q == TMO_LAST);

        unique case (key_rise)
            4'b0001: key_dir = 2'b00;
            4'b0010: key_dir = 2'b01;
            4'b0100: key_dir = 2'b10;
            4'b1000: key_dir = 2'b11;
            default: key_dir = 2'b00;
        endcase

        // Step 0 sits in the most significant pair of the latched sequence.
        case (step_q)
            3'd0:    expected_dir = seq_q[7:6];
            3'd1:    expected_dir = seq_q[5:4];
            3'd2:    expected_dir = seq_q[3:2];
            3'd3:    expected_dir = seq_q[1:0];
            default: expected_dir = 2'b00;
        endcase
    end

    // Round control FSM. All outputs are registered here alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            last_dir_q <= 2'b00;
            key_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            tmo_q      <= '0;
            seq_q      <= 8'h00;
        end else begin
            key_ack_q <= 1'b0;

            if (start) begin
                // Start beats any key event in the same cycle. The event is dropped.
                seq_q   <= sequence_i;
                step_q  <= 3'd0;
                tmo_q   <= '0;
                state_q <= ST_WAIT_KEY;
                busy_q  <= 1'b1;
                win_q   <= 1'b0;
                lose_q  <= 1'b0;
            end else if (state_q == ST_WAIT_KEY) begin
                if (key_event) begin
                    // Any key event is acknowledged and wins over a timeout in the same cycle.
                    key_ack_q <= 1'b1;
                    tmo_q     <= '0;
                    if (key_single) begin
                        last_dir_q <= key_dir;
                        if (key_dir == expected_dir) begin
                            step_q <= step_inc;
                            if (step_inc == 3'd4) begin
                                state_q <= ST_PASS;
                                busy_q  <= 1'b0;
                                win_q   <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_FAIL;
                            busy_q  <= 1'b0;
                            lose_q  <= 1'b1;
                        end
                    end else begin
                        // Several keys rising together count as a wrong key.
                        // The previous direction is kept.
                        state_q <= ST_FAIL;
                        busy_q  <= 1'b0;
                        lose_q  <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_q <= ST_FAIL;
                    busy_q  <= 1'b0;
                    lose_q  <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + CNT_ONE;
                end
            end
            // IDLE, PASS and FAIL hold all outputs until the next start.
        end
    end

    assign busy     = busy_q;
    assign step     = step_q;
    assign key_ack  = key_ack_q;
    assign last_dir = last_dir_q;
    assign win      = win_q;
    assign lose     = lose_q;

    // The round can never report a win and a loss at the same time.
    win_lose_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
        !(win_q && lose_q));

    // busy mirrors the WAIT_KEY state exactly.
    busy_tracks_state: assert property (@(posedge clock) disable iff (!reset_n)
        busy_q == (state_q == ST_WAIT_KEY));

endmodule

// File: tb/tb_player_sequence_checker.sv
// Scoreboard bench for player_sequence_checker. Stimulus pushes the expected
// sequence of output snapshots. A monitor compares each new snapshot as soon
// as the outputs change. Where timing matters, it also checks how many cycles
// the previous snapshot was held.
module tb_player_sequence_checker;

    localparam int TIMEOUT = 60;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       start      = 1'b0;
    logic [7:0] sequence_i = 8'h00;
    logic [3:0] key_press  = 4'b0000;
    logic       busy;
    logic [2:0] step;
    logic       key_ack;
    logic [1:0] last_dir;
    logic       win;
    logic       lose;

    // Snapshot field order: key_ack, busy, step, last_dir, win, lose.
    typedef struct packed {
        logic       ack;
        logic       busy;
        logic [2:0] step;
        logic [1:0] dir;
        logic       win;
        logic       lose;
    } snap_t;

    typedef struct {
        snap_t s;
        int    hold;   // required cycles this snapshot stays unchanged, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    player_sequence_checker #(.TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .sequence_i (sequence_i),
        .key_press  (key_press),
        .busy       (busy),
        .step       (step),
        .key_ack    (key_ack),
        .last_dir   (last_dir),
        .win        (win),
        .lose       (lose)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (ack,busy,step,dir,win,lose packed)", name, act, req);
        end
    endtask

    task automatic expect_out(input int a, input int b, input int s, input int d,
                              input int w, input int l, input int hold = -1);
        exp_t e;
        e.s    = {1'(a), 1'(b), 3'(s), 2'(d), 1'(w), 1'(l)};
        e.hold = hold;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] seq);
        sequence_i = seq;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic press(input logic [3:0] bits);
        key_press = bits;
        tick(1);
        key_press = 4'b0000;
        tick(2);
    endtask

    // Monitor: sample on the falling edge and pop one expectation per output change.
    initial begin
        snap_t cur;
        snap_t prev;
        exp_t  e;
        int    held;
        int    hold_req;
        int    idx;
        idx = 0;
        @(negedge clock);
        cur = {key_ack, busy, step, last_dir, win, lose};
        if (exp_q.size() == 0) begin
            check("reset snapshot present", 32'd0, 32'd1);
            hold_req = -1;
        end else begin
            e = exp_q.pop_front();
            check($sformatf("snapshot %0d", idx), 32'(cur), 32'(e.s));
            hold_req = e.hold;
        end
        held = 1;
        prev = cur;
        forever begin
            @(negedge clock);
            cur = {key_ack, busy, step, last_dir, win, lose};
            if (cur !== prev) begin
                if (hold_req >= 0)
                    check($sformatf("hold of snapshot %0d", idx), 32'(held), 32'(hold_req));
                idx++;
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected change, snapshot %0d", idx), 32'(cur), 32'(prev));
                    hold_req = -1;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("snapshot %0d", idx), 32'(cur), 32'(e.s));
                    hold_req = e.hold;
                end
                held = 1;
                prev = cur;
            end else begin
                held++;
            end
        end
    end

    // Directed stimulus with hand-computed expected snapshots.
    initial begin
        // Reset state. A key already high at release is ignored in IDLE.
        expect_out(0, 0, 0, 0, 0, 0);
        key_press = 4'b0100;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        key_press = 4'b0000;
        tick(2);

        // Full correct round on sequence 00_01_10_11.
        expect_out(0, 1, 0, 0, 0, 0);
        do_start(8'h1B);
        tick(1);
        expect_out(1, 1, 1, 0, 0, 0); expect_out(0, 1, 1, 0, 0, 0);
        press(4'b0001);
        expect_out(1, 1, 2, 1, 0, 0); expect_out(0, 1, 2, 1, 0, 0);
        press(4'b0010);
        expect_out(1, 1, 3, 2, 0, 0); expect_out(0, 1, 3, 2, 0, 0);
        press(4'b0100);
        expect_out(1, 0, 4, 3, 1, 0); expect_out(0, 0, 4, 3, 1, 0);
        press(4'b1000);
        press(4'b0001);                 // ignored in PASS

        // Wrong first key on sequence 11_00_00_00.
        expect_out(0, 1, 0, 3, 0, 0);
        do_start(8'hC0);
        tick(1);
        expect_out(1, 0, 0, 1, 0, 1); expect_out(0, 0, 0, 1, 0, 1);
        press(4'b0010);
        press(4'b0100);                 // ignored in FAIL

        // Timeout with no keys: busy for exactly TIMEOUT cycles, no key_ack.
        expect_out(0, 1, 0, 1, 0, 0, TIMEOUT);
        expect_out(0, 0, 0, 1, 0, 1);
        do_start(8'h00);
        tick(TIMEOUT + 5);

        // Two bits rising together: wrong key, last_dir kept. Bit0 stays held.
        expect_out(0, 1, 0, 1, 0, 0);
        do_start(8'h00);
        tick(1);
        expect_out(1, 0, 0, 1, 0, 1); expect_out(0, 0, 0, 1, 0, 1);
        key_press = 4'b0101;
        tick(1);
        key_press = 4'b0001;
        tick(2);
        // New start with bit0 still held: no event even though 00 would match.
        expect_out(0, 1, 0, 1, 0, 0);
        do_start(8'h00);
        tick(3);
        key_press = 4'b0000;
        tick(1);

        // Two correct keys, then reset mid-round: immediate IDLE, keys ignored afterwards.
        expect_out(1, 1, 1, 0, 0, 0); expect_out(0, 1, 1, 0, 0, 0);
        press(4'b0001);
        expect_out(1, 1, 2, 0, 0, 0); expect_out(0, 1, 2, 0, 0, 0);
        press(4'b0001);
        expect_out(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        press(4'b0010);
        tick(2);

        // Enter FAIL, then start with 8'hE4 together with a key rise.
        expect_out(0, 1, 0, 0, 0, 0);
        do_start(8'h00);
        tick(1);
        expect_out(1, 0, 0, 3, 0, 1); expect_out(0, 0, 0, 3, 0, 1);
        press(4'b1000);
        expect_out(0, 1, 0, 3, 0, 0);
        sequence_i = 8'hE4;
        start      = 1'b1;
        key_press  = 4'b1000;
        tick(1);
        start      = 1'b0;
        sequence_i = 8'h00;             // must not disturb the latched round
        key_press  = 4'b0000;
        tick(2);
        expect_out(1, 1, 1, 3, 0, 0); expect_out(0, 1, 1, 3, 0, 0);
        press(4'b1000);
        expect_out(1, 1, 2, 2, 0, 0); expect_out(0, 1, 2, 2, 0, 0);
        press(4'b0100);
        expect_out(1, 1, 3, 1, 0, 0); expect_out(0, 1, 3, 1, 0, 0);
        press(4'b0010);
        expect_out(1, 0, 4, 0, 1, 0); expect_out(0, 0, 4, 0, 1, 0);
        press(4'b0001);

        // Key on the last allowed cycle wins over the timeout. The counter then
        // restarts, and the next timeout leaves step unchanged.
        expect_out(0, 1, 0, 0, 0, 0, TIMEOUT);
        expect_out(1, 1, 1, 0, 0, 0, 1);
        expect_out(0, 1, 1, 0, 0, 0, TIMEOUT - 1);
        expect_out(0, 0, 1, 0, 0, 1);
        do_start(8'h00);
        tick(TIMEOUT - 1);
        key_press = 4'b0001;
        tick(1);
        key_press = 4'b0000;
        tick(TIMEOUT + 5);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_sequence_checker.md
PLAYER_SEQUENCE_CHECKER -- requirements
Module: player_sequence_checker

Interface
REQ-001 Parameter TIMEOUT, default 60, cycles allowed between accepted keys before a fail (legal range 2..2^20-1).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin checking against sequence.
REQ-005 sequence  input  8  expected directions; step 0 = [7:6], step 1 = [5:4], step 2 = [3:2], step 3 = [1:0].
REQ-006 key_press  input  4  level button inputs, one-hot direction: bit0=2'b00, bit1=2'b01, bit2=2'b10, bit3=2'b11.
REQ-007 busy  output  1  high in WAIT_KEY.
REQ-008 step  output  3  count of correct keys accepted in current round (0..4).
REQ-009 key_ack  output  1  one-cycle pulse per accepted key (correct or wrong).
REQ-010 last_dir  output  2  direction of most recently accepted key.
REQ-011 win  output  1  high in PASS.
REQ-012 lose  output  1  high in FAIL.

Function
REQ-013 States SHALL be IDLE, WAIT_KEY, PASS, FAIL; outputs are registered.
REQ-014 A key event SHALL be a 0->1 transition of any key_press bit versus its value registered the previous cycle; levels held high produce no further events.
REQ-015 start in any state SHALL latch sequence into an internal register, clear step to 0, clear the timeout counter, and enter WAIT_KEY next cycle.
REQ-016 start SHALL take priority over a key event in the same cycle; that key event is discarded.
REQ-017 In WAIT_KEY, exactly one rising bit SHALL be an accepted key: last_dir <= encoded direction, key_ack pulses next cycle, timeout counter clears.
REQ-018 Accepted key equal to the latched expected direction for index step SHALL increment step; if step becomes 4, state -> PASS.
REQ-019 Accepted key not equal to expected SHALL move state -> FAIL with step unchanged.
REQ-020 Two or more bits rising in the same cycle SHALL count as a wrong key: key_ack pulses, last_dir unchanged, state -> FAIL.
REQ-021 Timeout counter SHALL increment every WAIT_KEY cycle without an accepted key; when it equals TIMEOUT-1 with no key that cycle, state -> FAIL, no key_ack.
REQ-022 A key in the same cycle the counter reaches TIMEOUT-1 SHALL be processed normally (key wins over timeout).
REQ-023 Key events in IDLE, PASS, FAIL SHALL be ignored: no key_ack, no output change.
REQ-024 PASS and FAIL SHALL hold (win/lose steady) until start or reset.
REQ-025 Changes on the sequence input after start SHALL not affect the current round.
REQ-026 win and lose SHALL never be high simultaneously; busy SHALL equal (state == WAIT_KEY).

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, step=0, last_dir=2'b00, key_ack=0, win=0, lose=0, busy=0, timeout counter=0, latched sequence=8'h00, key edge register=4'b0000.
REQ-028 Reset asserted mid-round SHALL abandon the round; after release, block remains IDLE until start.
REQ-029 Key bits already high at reset release SHALL register as events on their first cycle after release but are ignored in IDLE.

Verification
REQ-030 sequence=8'b00_01_10_11, start, then key bits 0,1,2,3 one at a time -> four key_ack pulses, step 1..4, win=1, last_dir=2'b11.
REQ-031 sequence=8'b11_00_00_00, start, press bit1 -> key_ack, lose=1, step=0, last_dir=2'b01.
REQ-032 TIMEOUT=60, start, no keys -> busy for 60 cycles, then lose=1 with no key_ack.
REQ-033 start, bits 0 and 2 rise same cycle -> key_ack, lose=1, last_dir unchanged; hold bit0 high across a new start -> no second event.
REQ-034 start, two correct keys (step=2), assert reset_n low -> immediately IDLE, step=0, busy=0; release, press key -> no key_ack.
REQ-035 In FAIL, start with sequence=8'hE4 in the same cycle as a key rise -> key ignored, WAIT_KEY, step=0, lose=0, sequence 8'hE4 checked.
